alu_operand_xbar: RTL and testbench

Parametrised successor of the stage operand crossbar. Sits in each RMT stage between the PHV/action-engine outputs and the ALU array. It decodes one action word per PHV container and routes container values or immediates onto per-container ALU operand buses. Container counts and widths are configurable, and the action word is registered in the same beat as the operands it belongs to. A skid buffer provides a full valid/ready handshake with no loss under backpressure.

---
 rtl/alu_operand_xbar_if.sv | 34 +++
 rtl/alu_operand_xbar.sv | 151 +++++++++++++++
 tb/tb_alu_operand_xbar.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_xbar_if.sv
// Operand-crossbar bus: PHV/action input handshake plus registered ALU operand outputs.
interface alu_operand_xbar_if #(
  parameter int N6 = 8, N4 = 8, N2 = 8,
  parameter int W6 = 48, W4 = 32, W2 = 16,
  parameter int META_LEN = 256, ACT_LEN = 25
);
  localparam int NSLOT   = N6 + N4 + N2 + 1;
  localparam int PHV_LEN = N6*W6 + N4*W4 + N2*W2 + META_LEN;

  logic [PHV_LEN-1:0]       phv_in;
  logic                     phv_in_valid;
  logic [ACT_LEN*NSLOT-1:0] action_in;
  logic                     action_in_valid;
  logic                     in_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic [N6*W6-1:0]         alu_6B_a, alu_6B_b;
  logic [N4*W4-1:0]         alu_4B_a, alu_4B_b, alu_4B_c;
  logic [N2*W2-1:0]         alu_2B_a, alu_2B_b;
  logic [META_LEN-1:0]      meta_out;
  logic [ACT_LEN*NSLOT-1:0] action_out;
  logic [31:0]              stall_cnt;

  modport master (
    output phv_in, phv_in_valid, action_in, action_in_valid, out_ready,
    input  in_ready, out_valid, alu_6B_a, alu_6B_b, alu_4B_a, alu_4B_b, alu_4B_c,
           alu_2B_a, alu_2B_b, meta_out, action_out, stall_cnt
  );
  modport slave (
    input  phv_in, phv_in_valid, action_in, action_in_valid, out_ready,
    output in_ready, out_valid, alu_6B_a, alu_6B_b, alu_4B_a, alu_4B_b, alu_4B_c,
           alu_2B_a, alu_2B_b, meta_out, action_out, stall_cnt
  );
endinterface

// File: rtl/alu_operand_xbar.sv
// RMT stage operand crossbar: decodes one action slot per container into ALU a/b(/c)
// operands, registered together with metadata and action word behind a skid buffer.
module alu_operand_lane #(
  parameter int W = 32,
  parameter int N = 8,
  parameter int IDX = 0,
  parameter bit IS4B = 1'b0
) (
  input  logic [N*W-1:0] conts,
  input  logic [24:0]    slot,
  output logic [W-1:0]   a,
  output logic [W-1:0]   b
);
  logic [3:0]   op;
  logic [2:0]   sa, sb;
  logic [W-1:0] ca, cb, imm, self_v;

  assign op     = slot[24:21];
  assign sa     = slot[18:16];
  assign sb     = slot[13:11];
  assign imm    = W'(slot[15:0]);
  assign self_v = conts[IDX*W +: W];

  // selectors beyond the class population read as zero
  always_comb begin
    ca = '0;
    cb = '0;
    for (int k = 0; k < N; k++) begin
      if (sa == 3'(k)) ca = conts[k*W +: W];
      if (sb == 3'(k)) cb = conts[k*W +: W];
    end
  end

  always_comb begin
    a = self_v;
    b = '0;
    case (op)
      4'b0001, 4'b0010: begin a = ca; b = cb; end
      4'b1001, 4'b1010: begin a = ca; b = imm; end
      4'b1110:          begin a = '0; b = imm; end
      4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1011:
        if (IS4B) begin a = ca; b = cb; end
      4'b0011: if (IS4B) begin a = W'(slot[20:16]); b = imm; end
      4'b0100: if (IS4B) begin a = ca; b = W'(slot[13:11]); end
      default: ;
    endcase
  end
endmodule

module alu_operand_xbar #(
  parameter int STAGE_ID = 0,
  parameter int N6 = 8, N4 = 8, N2 = 8,
  parameter int W6 = 48, W4 = 32, W2 = 16,
  parameter int META_LEN = 256, ACT_LEN = 25
) (
  input logic         clk,
  input logic         rst_n,
  alu_operand_xbar_if.slave bus
);
  localparam int NSLOT   = N6 + N4 + N2 + 1;
  localparam int L6      = N6*W6;
  localparam int L4      = N4*W4;
  localparam int L2      = N2*W2;
  localparam int AL      = ACT_LEN*NSLOT;
  localparam int PHV_LEN = L6 + L4 + L2 + META_LEN;

  if (N6 < 1 || N6 > 8 || N4 < 1 || N4 > 8 || N2 < 1 || N2 > 8 ||
      W6 < 16 || W4 < 16 || W2 < 16 || ACT_LEN < 25 || STAGE_ID < 0) begin : g_bad_param
    $error("alu_operand_xbar: illegal parameter set");
  end

  typedef struct packed {
    logic [L6-1:0]       a6, b6;
    logic [L4-1:0]       a4, b4, c4;
    logic [L2-1:0]       a2, b2;
    logic [META_LEN-1:0] meta;
    logic [AL-1:0]       act;
  } beat_t;

  logic [L6-1:0] p6, a6, b6;
  logic [L4-1:0] p4, a4, b4, c4;
  logic [L2-1:0] p2, a2, b2;
  beat_t         dec, out_q, skid_q;
  logic          out_v, skid_v, acc, cons;
  logic [31:0]   stall_q;

  assign p6 = bus.phv_in[PHV_LEN-1 -: L6];
  assign p4 = bus.phv_in[L4+L2+META_LEN-1 -: L4];
  assign p2 = bus.phv_in[L2+META_LEN-1 -: L2];

  for (genvar g = 0; g < N6; g++) begin : g6
    alu_operand_lane #(.W(W6), .N(N6), .IDX(g), .IS4B(1'b0)) u_lane (
      .conts(p6), .slot(bus.action_in[(N2+N4+1+g)*ACT_LEN +: 25]),
      .a(a6[g*W6 +: W6]), .b(b6[g*W6 +: W6]));
  end

  for (genvar g = 0; g < N4; g++) begin : g4
    logic [24:0] slot;
    assign slot = bus.action_in[(N2+1+g)*ACT_LEN +: 25];
    alu_operand_lane #(.W(W4), .N(N4), .IDX(g), .IS4B(1'b1)) u_lane (
      .conts(p4), .slot(slot), .a(a4[g*W4 +: W4]), .b(b4[g*W4 +: W4]));
    // third operand: 11-bit literal for op 0100, own container otherwise
    assign c4[g*W4 +: W4] = (slot[24:21] == 4'b0100) ? W4'(slot[10:0]) : p4[g*W4 +: W4];
  end

  for (genvar g = 0; g < N2; g++) begin : g2
    alu_operand_lane #(.W(W2), .N(N2), .IDX(g), .IS4B(1'b0)) u_lane (
      .conts(p2), .slot(bus.action_in[(1+g)*ACT_LEN +: 25]),
      .a(a2[g*W2 +: W2]), .b(b2[g*W2 +: W2]));
  end

  assign dec  = {a6, b6, a4, b4, c4, a2, b2, bus.phv_in[META_LEN-1:0], bus.action_in};
  assign acc  = bus.phv_in_valid & bus.action_in_valid & ~skid_v;
  assign cons = out_v & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v   <= 1'b0;
      skid_v  <= 1'b0;
      out_q   <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      if (out_v && !bus.out_ready && stall_q != '1) stall_q <= stall_q + 32'd1;
      if (cons && skid_v) begin
        out_q  <= skid_q;
        skid_v <= 1'b0;
      end else if (!out_v || cons) begin
        out_v <= acc;
        if (acc) out_q <= dec;
      end else if (acc) begin
        skid_q <= dec;
        skid_v <= 1'b1;
      end
    end
  end

  // in_ready comes straight off the skid flop, so it is registered by construction
  assign bus.in_ready   = ~skid_v;
  assign bus.out_valid  = out_v;
  assign bus.alu_6B_a   = out_q.a6;
  assign bus.alu_6B_b   = out_q.b6;
  assign bus.alu_4B_a   = out_q.a4;
  assign bus.alu_4B_b   = out_q.b4;
  assign bus.alu_4B_c   = out_q.c4;
  assign bus.alu_2B_a   = out_q.a2;
  assign bus.alu_2B_b   = out_q.b2;
  assign bus.meta_out   = out_q.meta;
  assign bus.action_out = out_q.act;
  assign bus.stall_cnt  = stall_q;
endmodule

// File: tb/tb_alu_operand_xbar.sv
// Directed bench for alu_operand_xbar on a reduced build (N6=2, N4=4, N2=3, 16-bit metadata).
module tb_alu_operand_xbar;
  localparam int N6 = 2, N4 = 4, N2 = 3, W6 = 48, W4 = 32, W2 = 16, ML = 16, AL = 25;
  localparam int NS = N6 + N4 + N2 + 1;
  localparam int PL = N6*W6 + N4*W4 + N2*W2 + ML;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_operand_xbar_if #(.N6(N6), .N4(N4), .N2(N2), .W6(W6), .W4(W4), .W2(W2),
                        .META_LEN(ML), .ACT_LEN(AL)) bus();
  alu_operand_xbar #(.STAGE_ID(3), .N6(N6), .N4(N4), .N2(N2), .W6(W6), .W4(W4), .W2(W2),
                     .META_LEN(ML), .ACT_LEN(AL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad = 0;
  logic [W6-1:0] c6 [N6];
  logic [W4-1:0] c4 [N4];
  logic [W2-1:0] c2 [N2];
  logic [AL-1:0] sl [NS];
  logic [AL*NS-1:0] exp_act;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AL-1:0] mk(input logic [3:0] op, input logic [4:0] x, input logic [15:0] imm);
    return {op, x, imm};
  endfunction

  function automatic logic [AL*NS-1:0] act_word();
    logic [AL*NS-1:0] w;
    w = '0;
    for (int k = 0; k < NS; k++) w[k*AL +: AL] = sl[k];
    return w;
  endfunction

  task automatic drive(input logic [ML-1:0] meta);
    logic [PL-1:0] p;
    p = '0;
    for (int i = 0; i < N6; i++) p[ML + N2*W2 + N4*W4 + i*W6 +: W6] = c6[i];
    for (int i = 0; i < N4; i++) p[ML + N2*W2 + i*W4 +: W4] = c4[i];
    for (int i = 0; i < N2; i++) p[ML + i*W2 +: W2] = c2[i];
    p[ML-1:0] = meta;
    bus.phv_in = p;
    bus.action_in = act_word();
  endtask

  task automatic clr_slots();
    for (int k = 0; k < NS; k++) sl[k] = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.phv_in = '0;
    bus.action_in = '0;
    bus.phv_in_valid = 1'b0;
    bus.action_in_valid = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < N6; i++) c6[i] = 48'hA000_0000_0010 + 48'(i);
    c4[0] = 32'd3; c4[1] = 32'd5; c4[2] = 32'd6; c4[3] = 32'd7;
    for (int i = 0; i < N2; i++) c2[i] = 16'h2000 + 16'(i);
    clr_slots();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 256'(bus.in_ready), 256'd1);
    chk("rst_out_valid", 256'(bus.out_valid), 256'd0);
    chk("rst_stall", 256'(bus.stall_cnt), 256'd0);
    chk("rst_6B_a", 256'(bus.alu_6B_a), 256'd0);
    chk("rst_4B_c", 256'(bus.alu_4B_c), 256'd0);
    chk("rst_meta", 256'(bus.meta_out), 256'd0);
    chk("rst_action", 256'(bus.action_out), 256'd0);
    rst_n = 1'b1;
    step();
    chk("idle_out_valid", 256'(bus.out_valid), 256'd0);
    chk("idle_in_ready", 256'(bus.in_ready), 256'd1);

    // 4B lane 2: op 0001, srcA=1, srcB=3; everything else all-zero action
    sl[N2+1+2] = mk(4'b0001, 5'd1, 16'h1800);
    drive(16'hCAFE);
    exp_act = act_word();
    bus.phv_in_valid = 1'b1;
    bus.action_in_valid = 1'b1;
    bus.out_ready = 1'b1;
    step();
    chk("A_out_valid", 256'(bus.out_valid), 256'd1);
    chk("A_4B_a2", 256'(bus.alu_4B_a[2*W4 +: W4]), 256'd5);
    chk("A_4B_b2", 256'(bus.alu_4B_b[2*W4 +: W4]), 256'd7);
    chk("A_4B_c2", 256'(bus.alu_4B_c[2*W4 +: W4]), 256'd6);
    chk("A_4B_a0", 256'(bus.alu_4B_a[0 +: W4]), 256'd3);
    chk("A_4B_b0", 256'(bus.alu_4B_b[0 +: W4]), 256'd0);
    chk("A_action", 256'(bus.action_out), 256'(exp_act));
    chk("A_meta", 256'(bus.meta_out), 256'hCAFE);
    for (int i = 0; i < N6; i++) begin
      chk("A_6B_a_self", 256'(bus.alu_6B_a[i*W6 +: W6]), 256'(c6[i]));
      chk("A_6B_b_zero", 256'(bus.alu_6B_b[i*W6 +: W6]), 256'd0);
    end
    for (int i = 0; i < N2; i++) chk("A_2B_a_self", 256'(bus.alu_2B_a[i*W2 +: W2]), 256'(c2[i]));

    // 6B op 1110 imm BEEF, 2B lane 0 op 1001 srcA=2 imm 1234, slot 0 passthrough
    clr_slots();
    sl[0] = 25'h1ABCDEF;
    sl[N2+N4+1] = mk(4'b1110, 5'd0, 16'hBEEF);
    sl[N2+N4+2] = mk(4'b1110, 5'd0, 16'hBEEF);
    sl[1] = mk(4'b1001, 5'd2, 16'h1234);
    drive(16'h1111);
    exp_act = act_word();
    step();
    chk("B_6B_a0", 256'(bus.alu_6B_a[0 +: W6]), 256'd0);
    chk("B_6B_b0", 256'(bus.alu_6B_b[0 +: W6]), 256'h0000_0000_BEEF);
    chk("B_6B_a1", 256'(bus.alu_6B_a[W6 +: W6]), 256'd0);
    chk("B_6B_b1", 256'(bus.alu_6B_b[W6 +: W6]), 256'h0000_0000_BEEF);
    chk("B_2B_a0", 256'(bus.alu_2B_a[0 +: W2]), 256'h2002);
    chk("B_2B_b0", 256'(bus.alu_2B_b[0 +: W2]), 256'h1234);
    chk("B_action", 256'(bus.action_out), 256'(exp_act));

    // 4B-only ops, out-of-range selector, 4B-only op on a 2B lane
    clr_slots();
    sl[N2+1+0] = mk(4'b0100, 5'd1, 16'h2FFF);
    sl[N2+1+1] = mk(4'b0011, 5'h1F, 16'h1234);
    sl[N2+1+3] = mk(4'b0101, 5'd6, 16'h0000);
    sl[2] = mk(4'b0101, 5'd1, 16'h0000);
    drive(16'h2222);
    step();
    chk("C_4B_a0", 256'(bus.alu_4B_a[0 +: W4]), 256'd5);
    chk("C_4B_b0", 256'(bus.alu_4B_b[0 +: W4]), 256'd5);
    chk("C_4B_c0", 256'(bus.alu_4B_c[0 +: W4]), 256'h7FF);
    chk("C_4B_a1", 256'(bus.alu_4B_a[W4 +: W4]), 256'h1F);
    chk("C_4B_b1", 256'(bus.alu_4B_b[W4 +: W4]), 256'h1234);
    chk("C_4B_c1", 256'(bus.alu_4B_c[W4 +: W4]), 256'd5);
    chk("C_4B_a3_oor", 256'(bus.alu_4B_a[3*W4 +: W4]), 256'd0);
    chk("C_4B_b3", 256'(bus.alu_4B_b[3*W4 +: W4]), 256'd3);
    chk("C_2B_a1", 256'(bus.alu_2B_a[W2 +: W2]), 256'h2001);
    chk("C_2B_b1", 256'(bus.alu_2B_b[W2 +: W2]), 256'd0);

    // only one of the two valids high: nothing accepted
    bus.action_in_valid = 1'b0;
    step();
    chk("D_phv_only", 256'(bus.out_valid), 256'd0);
    step();
    chk("D_phv_only2", 256'(bus.out_valid), 256'd0);
    bus.phv_in_valid = 1'b0;
    bus.action_in_valid = 1'b1;
    step();
    chk("D_act_only", 256'(bus.out_valid), 256'd0);
    chk("D_stall", 256'(bus.stall_cnt), 256'd0);

    // streaming with out_ready low for three cycles
    clr_slots();
    bus.phv_in_valid = 1'b1;
    bus.action_in_valid = 1'b1;
    bus.out_ready = 1'b0;
    drive(16'hB000);
    step();
    chk("E0_valid", 256'(bus.out_valid), 256'd1);
    chk("E0_meta", 256'(bus.meta_out), 256'hB000);
    chk("E0_in_ready", 256'(bus.in_ready), 256'd1);
    drive(16'hB001);
    step();
    chk("E1_in_ready", 256'(bus.in_ready), 256'd0);
    chk("E1_meta_hold", 256'(bus.meta_out), 256'hB000);
    chk("E1_stall", 256'(bus.stall_cnt), 256'd1);
    drive(16'hB002);
    step();
    chk("E2_in_ready", 256'(bus.in_ready), 256'd0);
    chk("E2_meta_hold", 256'(bus.meta_out), 256'hB000);
    step();
    chk("E3_stall", 256'(bus.stall_cnt), 256'd3);
    chk("E3_meta_hold", 256'(bus.meta_out), 256'hB000);
    bus.out_ready = 1'b1;
    step();
    chk("E4_meta_skid", 256'(bus.meta_out), 256'hB001);
    chk("E4_valid", 256'(bus.out_valid), 256'd1);
    chk("E4_in_ready", 256'(bus.in_ready), 256'd1);
    step();
    chk("E5_meta", 256'(bus.meta_out), 256'hB002);
    drive(16'hB003);
    step();
    chk("E6_meta", 256'(bus.meta_out), 256'hB003);
    bus.phv_in_valid = 1'b0;
    bus.action_in_valid = 1'b0;
    step();
    chk("E7_drained", 256'(bus.out_valid), 256'd0);
    chk("E7_stall", 256'(bus.stall_cnt), 256'd3);

    // reset asserted mid-stream with the skid full
    bus.phv_in_valid = 1'b1;
    bus.action_in_valid = 1'b1;
    bus.out_ready = 1'b0;
    drive(16'hD00D);
    step();
    step();
    chk("F_skid_full", 256'(bus.in_ready), 256'd0);
    chk("F_stall", 256'(bus.stall_cnt), 256'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("F_rst_valid", 256'(bus.out_valid), 256'd0);
    chk("F_rst_in_ready", 256'(bus.in_ready), 256'd1);
    chk("F_rst_stall", 256'(bus.stall_cnt), 256'd0);
    chk("F_rst_meta", 256'(bus.meta_out), 256'd0);
    bus.phv_in_valid = 1'b0;
    bus.action_in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("F_post_valid", 256'(bus.out_valid), 256'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
